// File: rtl/lockstep_checker.sv
// rtl/lockstep_checker.sv - lockstep retirement comparator with per-side skew FIFOs
// Scores DUT vs model writeback records in retire order and reports pass/fail.
module lockstep_checker #(
  parameter int DATA_W       = 16,
  parameter int TAG_W        = 4,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT      = 1000000,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_pc,
  input  logic              dut_we,
  input  logic [TAG_W-1:0]  dut_rd,
  input  logic [DATA_W-1:0] dut_data,
  input  logic              dut_hlt,
  input  logic              mdl_valid,
  input  logic [DATA_W-1:0] mdl_pc,
  input  logic              mdl_we,
  input  logic [TAG_W-1:0]  mdl_rd,
  input  logic [DATA_W-1:0] mdl_data,
  input  logic              mdl_hlt,
  output logic [1:0]        state,
  output logic [31:0]       match_cnt,
  output logic [15:0]       mismatch_cnt,
  output logic [DATA_W-1:0] first_fail_pc,
  output logic [31:0]       first_fail_idx,
  output logic              overflow,
  output logic              timed_out,
  output logic              pass,
  output logic              fail
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_FAIL = 2'b11
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              we;
    logic [TAG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t dut_mem_q [DEPTH];
  rec_t mdl_mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [PW-1:0]     dut_wp_q, dut_wp_d, dut_rp_q, dut_rp_d;
  logic [PW-1:0]     mdl_wp_q, mdl_wp_d, mdl_rp_q, mdl_rp_d;
  logic              dut_hlt_q, dut_hlt_d, mdl_hlt_q, mdl_hlt_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       cmp_idx_q, cmp_idx_d;
  logic [31:0]       match_cnt_q, match_cnt_d;
  logic [15:0]       mismatch_cnt_q, mismatch_cnt_d;
  logic [DATA_W-1:0] first_fail_pc_q, first_fail_pc_d;
  logic [31:0]       first_fail_idx_q, first_fail_idx_d;
  logic              overflow_q, overflow_d;
  logic              timed_out_q, timed_out_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  rec_t dut_rec, mdl_rec, dut_head, mdl_head;
  logic dut_empty, mdl_empty, dut_full, mdl_full;
  logic running, halted, hold_cmp;
  logic pair_pop, dut_orphan, mdl_orphan, dut_pop, mdl_pop;
  logic dut_push, mdl_push, ovf_evt;
  logic rec_diff, hit_evt, miss_evt, cmp_evt;

  assign dut_rec  = {dut_pc, dut_we, dut_rd, dut_data};
  assign mdl_rec  = {mdl_pc, mdl_we, mdl_rd, mdl_data};
  assign dut_head = dut_mem_q[dut_rp_q[AW-1:0]];
  assign mdl_head = mdl_mem_q[mdl_rp_q[AW-1:0]];

  assign dut_empty = (dut_wp_q == dut_rp_q);
  assign mdl_empty = (mdl_wp_q == mdl_rp_q);
  assign dut_full  = (dut_wp_q[PW-1] != dut_rp_q[PW-1]) && (dut_wp_q[AW-1:0] == dut_rp_q[AW-1:0]);
  assign mdl_full  = (mdl_wp_q[PW-1] != mdl_rp_q[PW-1]) && (mdl_wp_q[AW-1:0] == mdl_rp_q[AW-1:0]);

  // A latched mismatch with STOP_ON_FAIL freezes the scoreboard until the FAIL transition.
  assign running  = (state_q == S_RUN);
  assign halted   = dut_hlt_q && mdl_hlt_q;
  assign hold_cmp = (STOP_ON_FAIL != 0) && (mismatch_cnt_q != 16'd0);

  assign pair_pop   = running && !hold_cmp && !dut_empty && !mdl_empty;
  assign dut_orphan = running && !hold_cmp && halted && !dut_empty && mdl_empty;
  assign mdl_orphan = running && !hold_cmp && halted && dut_empty && !mdl_empty;
  assign dut_pop    = pair_pop || dut_orphan;
  assign mdl_pop    = pair_pop || mdl_orphan;

  assign dut_push = running && dut_valid && (!dut_full || dut_pop);
  assign mdl_push = running && mdl_valid && (!mdl_full || mdl_pop);
  assign ovf_evt  = running && ((dut_valid && dut_full && !dut_pop) ||
                                (mdl_valid && mdl_full && !mdl_pop));

  assign rec_diff = (dut_head.pc != mdl_head.pc) || (dut_head.we != mdl_head.we) ||
                    (dut_head.rd != mdl_head.rd) ||
                    (dut_head.we && (dut_head.data != mdl_head.data));
  assign hit_evt  = pair_pop && !rec_diff;
  assign miss_evt = (pair_pop && rec_diff) || dut_orphan || mdl_orphan;
  assign cmp_evt  = dut_pop || mdl_pop;

  always_comb begin
    state_d          = state_q;
    dut_wp_d         = dut_wp_q;
    dut_rp_d         = dut_rp_q;
    mdl_wp_d         = mdl_wp_q;
    mdl_rp_d         = mdl_rp_q;
    dut_hlt_d        = dut_hlt_q;
    mdl_hlt_d        = mdl_hlt_q;
    cyc_d            = cyc_q;
    cmp_idx_d        = cmp_idx_q;
    match_cnt_d      = match_cnt_q;
    mismatch_cnt_d   = mismatch_cnt_q;
    first_fail_pc_d  = first_fail_pc_q;
    first_fail_idx_d = first_fail_idx_q;
    overflow_d       = overflow_q;
    timed_out_d      = timed_out_q;

    if (dut_push) dut_wp_d = dut_wp_q + PW'(1);
    if (mdl_push) mdl_wp_d = mdl_wp_q + PW'(1);
    if (dut_pop)  dut_rp_d = dut_rp_q + PW'(1);
    if (mdl_pop)  mdl_rp_d = mdl_rp_q + PW'(1);

    if (cmp_evt) cmp_idx_d = cmp_idx_q + 32'd1;
    if (hit_evt && (match_cnt_q != '1)) match_cnt_d = match_cnt_q + 32'd1;
    if (miss_evt) begin
      if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + 16'd1;
      if (mismatch_cnt_q == 16'd0) begin
        first_fail_pc_d  = mdl_orphan ? mdl_head.pc : dut_head.pc;
        first_fail_idx_d = cmp_idx_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cyc_d   = 32'd0;
        end
      end
      S_RUN: begin
        cyc_d     = cyc_q + 32'd1;
        dut_hlt_d = dut_hlt_q || dut_hlt;
        mdl_hlt_d = mdl_hlt_q || mdl_hlt;
        if (ovf_evt) begin
          state_d    = S_FAIL;
          overflow_d = 1'b1;
        end else if (hold_cmp) begin
          state_d = S_FAIL;
        end else if (cyc_q + 32'd1 == 32'(TIMEOUT)) begin
          state_d     = S_FAIL;
          timed_out_d = 1'b1;
        end else if (halted && dut_empty && mdl_empty && !dut_push && !mdl_push) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (mismatch_cnt_q != 16'd0) state_d = S_FAIL;
      end
      default: state_d = S_FAIL;
    endcase

    pass_d = (state_d == S_DONE) && (mismatch_cnt_d == 16'd0) && !overflow_d;
    fail_d = (state_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (dut_push) dut_mem_q[dut_wp_q[AW-1:0]] <= dut_rec;
    if (mdl_push) mdl_mem_q[mdl_wp_q[AW-1:0]] <= mdl_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      dut_wp_q         <= '0;
      dut_rp_q         <= '0;
      mdl_wp_q         <= '0;
      mdl_rp_q         <= '0;
      dut_hlt_q        <= 1'b0;
      mdl_hlt_q        <= 1'b0;
      cyc_q            <= '0;
      cmp_idx_q        <= '0;
      match_cnt_q      <= '0;
      mismatch_cnt_q   <= '0;
      first_fail_pc_q  <= '0;
      first_fail_idx_q <= '0;
      overflow_q       <= 1'b0;
      timed_out_q      <= 1'b0;
      pass_q           <= 1'b0;
      fail_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      dut_wp_q         <= dut_wp_d;
      dut_rp_q         <= dut_rp_d;
      mdl_wp_q         <= mdl_wp_d;
      mdl_rp_q         <= mdl_rp_d;
      dut_hlt_q        <= dut_hlt_d;
      mdl_hlt_q        <= mdl_hlt_d;
      cyc_q            <= cyc_d;
      cmp_idx_q        <= cmp_idx_d;
      match_cnt_q      <= match_cnt_d;
      mismatch_cnt_q   <= mismatch_cnt_d;
      first_fail_pc_q  <= first_fail_pc_d;
      first_fail_idx_q <= first_fail_idx_d;
      overflow_q       <= overflow_d;
      timed_out_q      <= timed_out_d;
      pass_q           <= pass_d;
      fail_q           <= fail_d;
    end
  end

  assign state          = state_q;
  assign match_cnt      = match_cnt_q;
  assign mismatch_cnt   = mismatch_cnt_q;
  assign first_fail_pc  = first_fail_pc_q;
  assign first_fail_idx = first_fail_idx_q;
  assign overflow       = overflow_q;
  assign timed_out      = timed_out_q;
  assign pass           = pass_q;
  assign fail           = fail_q;

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Synthesizable, parametrised lockstep comparator for retirement streams from the pipelined CPU and its reference model.
- Each side pushes one writeback record per retire into its own skew FIFO. Heads are compared in order, one pair per cycle.
- Counts matches and mismatches, captures the first failure, detects halt completion and timeout, and reports pass/fail.
- Replaces per-stage negedge checks with a depth-tolerant scoreboard usable in simulation and on FPGA.

Parameters:
DATA_W, 16, width of PC and writeback data fields
TAG_W, 4, width of destination-register tag
DEPTH, 8, entries per skew FIFO (power of two, >=2)
TIMEOUT, 1000000, RUN-state cycles before timeout failure
STOP_ON_FAIL, 1, 1 = enter FAIL on first mismatch; 0 = keep counting until halt

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin checking (sampled in IDLE only)
dut_valid  in  1  DUT retire record valid this cycle
dut_pc  in  DATA_W  DUT retiring PC
dut_we  in  1  DUT register write enable
dut_rd  in  TAG_W  DUT destination register
dut_data  in  DATA_W  DUT writeback data
dut_hlt  in  1  DUT halt reached WB
mdl_valid, mdl_pc, mdl_we, mdl_rd, mdl_data, mdl_hlt  in  1/DATA_W/1/TAG_W/DATA_W/1  model counterparts
state  out  2  00 IDLE, 01 RUN, 10 DONE, 11 FAIL
match_cnt  out  32  compared pairs that matched
mismatch_cnt  out  16  mismatches, including orphans
first_fail_pc  out  DATA_W  DUT PC of first mismatch (model PC if orphan from model)
first_fail_idx  out  32  compare index (0-based) of first mismatch
overflow  out  1  sticky: push into full FIFO
timed_out  out  1  sticky: TIMEOUT reached
pass  out  1  high in DONE with mismatch_cnt==0 and no overflow
fail  out  1  high in FAIL

Behaviour:
- Reset (rst_n low at posedge): state=IDLE. All counters, FIFO pointers, halt latches, first_fail_* and sticky flags = 0. pass=fail=0. Reset mid-run discards all buffered records.
- IDLE: pushes ignored. start=1 -> RUN next cycle, cycle counter cleared.
- RUN push: each side writes its record {pc,we,rd,data} when valid=1. Push and pop on the same FIFO in the same cycle are both legal, including when the FIFO is full.
- RUN overflow: push into a full FIFO with no same-cycle pop drops the record, sets overflow, and goes to FAIL next cycle.
- Compare: when both FIFOs are non-empty, pop both heads in the same cycle.
  - Mismatch if pc, we or rd differs, or if we=1 and data differs. Data is ignored when both we=0.
  - Counters and first_fail_* update at that edge, visible the next cycle. Latency from the later push to count update is 2 cycles.
  - Both counters saturate at all-ones.
- Halt latch: dut_hlt/mdl_hlt are latched sticky while in RUN.
- Orphans: once both halts are latched and exactly one FIFO is non-empty, pop one orphan per cycle and count it as a mismatch.
- RUN -> DONE: both halts latched, both FIFOs empty, no pending failure.
- RUN -> FAIL, any of:
  - mismatch with STOP_ON_FAIL=1 (state changes the cycle after the count update);
  - overflow;
  - cycle counter reaches TIMEOUT, which sets timed_out.
- Priority at the same edge: overflow > mismatch > timeout > DONE.
- DONE with mismatch_cnt!=0 (possible only when STOP_ON_FAIL=0) -> FAIL next cycle. Otherwise pass=1.
- DONE and FAIL are terminal until reset. All inputs are ignored and outputs hold.
- Pointer wrap: each pointer is log2(DEPTH)+1 bits. Full = MSBs differ and low bits equal. Empty = pointers equal.

Test Plan:
1. Reset, start, then 5 identical records on both sides in the same cycles, then both hlt -> match_cnt=5, mismatch_cnt=0, state=DONE, pass=1.
2. Model leads DUT by 7 cycles with identical 20-record streams, DEPTH=8 -> no overflow, match_cnt=20, DONE.
3. Record #3 has dut_data=16'h0012 vs mdl_data=16'h0013, we=1, pc=16'h0006, STOP_ON_FAIL=1 -> first_fail_idx=3, first_fail_pc=16'h0006, mismatch_cnt=1, FAIL.
4. Record has differing data but we=0 on both sides -> counted as a match.
5. STOP_ON_FAIL=0; model retires 2 extra records before both halt -> mismatch_cnt=2 orphans, transits DONE -> FAIL.
6. 9 model pushes with no DUT pushes, DEPTH=8 -> overflow=1, FAIL. Separately: TIMEOUT=50 with no halts -> timed_out=1, FAIL at cycle 50. Asserting rst_n=0 mid-run -> all outputs return to reset values at the next edge.
